// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants, frame-timing helpers and the arbiter state
//                encoding for the UART transmit arbiter.
//                FRAME_BITS    - bit periods occupied by one frame on the line
//                baud_divisor  - clk cycles per bit (integer truncation, same
//                                rounding as the downstream uart_tx)
//                frame_cycles  - clk cycles reserved per frame, counted from
//                                the start pulse, including the idle gap
//                arb_state_t   - arbiter FSM states
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int FRAME_BITS = 11;

    function automatic int baud_divisor(input int clock_frequency,
                                        input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

    // The extra cycle covers uart_tx registering start before driving the
    // start bit; the gap guarantees a clean stop level between frames.
    function automatic int frame_cycles(input int clock_frequency,
                                        input int baud_rate,
                                        input int gap_cycles);
        return FRAME_BITS * baud_divisor(clock_frequency, baud_rate) + 1 + gap_cycles;
    endfunction

    typedef enum logic [1:0] {
        HOLDOFF = 2'd0,
        IDLE    = 2'd1,
        LAUNCH  = 2'd2,
        WAIT    = 2'd3
    } arb_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational round-robin arbiter. Grants the first
//                requester at or after ptr+1 (mod N). When lock is set only
//                lock_id may be granted, and nothing is granted if it is not
//                requesting.
//  Ports       : req[N]        request vector
//                ptr[W]        index of the most recent winner
//                lock          restrict grant to lock_id
//                lock_id[W]    locked requester index
//                grant[N]      one-hot grant (all zero if none)
//                grant_idx[W]  encoded grant index (0 when none)
//                grant_any     a grant is being issued
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         lock,
    input  logic [W-1:0] lock_id,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         grant_any
);

    int w_cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        w_cand    = 0;
        if (lock) begin
            if (req[lock_id]) begin
                grant[lock_id] = 1'b1;
                grant_idx      = lock_id;
                grant_any      = 1'b1;
            end
        end else begin
            // Scan offsets 1..N so the previous winner is considered last.
            for (int k = 1; k <= N; k++) begin
                w_cand = (int'(ptr) + k) % N;
                if (!grant_any && req[W'(w_cand)]) begin
                    grant[W'(w_cand)] = 1'b1;
                    grant_idx         = W'(w_cand);
                    grant_any         = 1'b1;
                end
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one uart_tx among NUM_REQ byte sources with
//                round-robin fairness. Accepts one byte per frame over
//                valid/ready, pulses tx_start and holds tx_data for the whole
//                frame. uart_tx has no busy output, so frame length is timed
//                locally; after reset a full frame time is waited out in case
//                uart_tx (which has no reset) was mid-frame.
//  Ports       : clk, rst       clock, synchronous active-high reset
//                req_valid[N]   requester i offers req_data[8*i+:8]
//                req_data[8N]   packed request bytes
//                req_ready[N]   one-hot accept, only in IDLE
//                tx_start       one-cycle start pulse to uart_tx
//                tx_data[8]     byte to uart_tx, stable for the frame
//                busy           high whenever not in IDLE
//                grant_id       index of the last accepted requester
//                req_last[N]    (UART_ARB_PACKET_LOCK_EN only) last byte of a
//                               packet; keeps the grant until it is accepted
//  Config      : UART_ARB_PACKET_LOCK_EN - enables packet locking
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int BAUD_RATE       = 115200,
    parameter int GAP_CYCLES      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [8*NUM_REQ-1:0]         req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx_start,
    output logic [7:0]                   tx_data,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id
`ifdef UART_ARB_PACKET_LOCK_EN
    ,
    input  logic [NUM_REQ-1:0]           req_last
`endif
);

    localparam int c_IDX_W        = $clog2(NUM_REQ);
    localparam int c_FRAME_CYCLES = frame_cycles(CLOCK_FREQUENCY, BAUD_RATE, GAP_CYCLES);
    // Holds up to FRAME_CYCLES: the counter steps once more on the exit edge.
    localparam int c_CNT_W        = $clog2(c_FRAME_CYCLES + 1);

    arb_state_t           r_state;
    arb_state_t           w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [7:0]           r_tx_data;
    logic [c_IDX_W-1:0]   r_grant_id;
    logic [c_IDX_W-1:0]   r_ptr;
    logic                 w_lock;

    logic [NUM_REQ-1:0]   w_grant;
    logic [c_IDX_W-1:0]   w_grant_idx;
    logic                 w_grant_any;
    logic                 w_accept;
    logic                 w_cnt_last;
    logic [7:0]           w_sel_data;
    logic [NUM_REQ-1:0]   w_ready;
    logic                 w_tx_start;
    logic                 w_busy;

`ifdef UART_ARB_PACKET_LOCK_EN
    logic                 r_lock;

    // Lock engages after any accepted byte that is not the packet's last.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock <= 1'b0;
        end else if (w_accept) begin
            r_lock <= ~req_last[w_grant_idx];
        end
    end

    assign w_lock = r_lock;
`else
    assign w_lock = 1'b0;
`endif

    rr_arbiter #(
        .N (NUM_REQ),
        .W (c_IDX_W)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (r_ptr),
        .lock      (w_lock),
        .lock_id   (r_grant_id),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .grant_any (w_grant_any)
    );

    assign w_cnt_last = (r_cnt == c_CNT_W'(c_FRAME_CYCLES - 1));
    assign w_accept   = (r_state == IDLE) && w_grant_any;

    always_comb begin
        w_sel_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_data = req_data[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HOLDOFF;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = '0;
        w_tx_start   = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            HOLDOFF: begin
                if (w_cnt_last) begin
                    w_state_next = IDLE;
                end
            end
            IDLE: begin
                w_busy  = 1'b0;
                w_ready = w_grant;
                if (w_grant_any) begin
                    w_state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                w_tx_start   = 1'b1;
                w_state_next = WAIT;
            end
            WAIT: begin
                if (w_cnt_last) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = HOLDOFF;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame counter: the LAUNCH cycle is count 0, so WAIT starts at 1.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE:    r_cnt <= '0;
                LAUNCH:  r_cnt <= c_CNT_W'(1);
                default: r_cnt <= r_cnt + c_CNT_W'(1);
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Accepted byte, grant record and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_data  <= 8'h00;
            r_grant_id <= '0;
            r_ptr      <= c_IDX_W'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_tx_data  <= w_sel_data;
            r_grant_id <= w_grant_idx;
            r_ptr      <= w_grant_idx;
        end
    end

    assign req_ready = w_ready;
    assign tx_start  = w_tx_start;
    assign tx_data   = r_tx_data;
    assign busy      = w_busy;
    assign grant_id  = r_grant_id;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Directed self-checking bench for uart_tx_arbiter with
//                CLOCK_FREQUENCY=1000000, BAUD_RATE=100000, GAP_CYCLES=2,
//                giving FRAME_CYCLES=113 and accept spacing of 114 cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic [1:0]  grant_id;
`ifdef UART_ARB_PACKET_LOCK_EN
    logic [3:0]  req_last;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  last_data = 8'h00;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ         (4),
        .CLOCK_FREQUENCY (1000000),
        .BAUD_RATE       (100000),
        .GAP_CYCLES      (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .busy      (busy),
        .grant_id  (grant_id)
`ifdef UART_ARB_PACKET_LOCK_EN
        ,
        .req_last  (req_last)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called right after the reset edge with rst already released: 112 more
    // busy cycles, then IDLE on the 113th edge.
    task automatic holdoff_check(input logic [3:0] exp_ready);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 112; i++) begin
            tick();
            if (busy !== 1'b1 || req_ready !== 4'b0000 || tx_start !== 1'b0) bad = 1'b1;
        end
        check("holdoff_busy_noready_nostart", {31'd0, bad}, 32'd0);
        tick();
        check("holdoff_release_busy", {31'd0, busy}, 32'd0);
        check("holdoff_release_ready", {28'd0, req_ready}, {28'd0, exp_ready});
    endtask

    // Wait for ready, check the winner and spacing, then the launch cycle.
    task automatic do_grant(input int exp_idx, input logic [7:0] exp_data, input int exp_wait);
        int   waited;
        logic glitch;
        waited = 0;
        glitch = 1'b0;
        while (req_ready === 4'b0000 && waited < 300) begin
            if (tx_start !== 1'b0 || tx_data !== last_data) glitch = 1'b1;
            tick();
            waited++;
        end
        check("wait_start_low_data_stable", {31'd0, glitch}, 32'd0);
        check("accept_spacing", waited, exp_wait);
        check("ready_onehot", {28'd0, req_ready}, 32'd1 << exp_idx);
        tick();
        check("launch_tx_start", {31'd0, tx_start}, 32'd1);
        check("launch_tx_data", {24'd0, tx_data}, {24'd0, exp_data});
        check("launch_grant_id", {30'd0, grant_id}, exp_idx);
        check("launch_busy", {31'd0, busy}, 32'd1);
        check("launch_ready_low", {28'd0, req_ready}, 32'd0);
        last_data = exp_data;
        tick();
        check("start_one_cycle", {31'd0, tx_start}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 4'b0000;
        req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
`ifdef UART_ARB_PACKET_LOCK_EN
        req_last  = 4'b1111;
`endif
        tick();
        tick();
        tick();
        check("reset_busy", {31'd0, busy}, 32'd1);
        check("reset_ready", {28'd0, req_ready}, 32'd0);
        check("reset_tx_start", {31'd0, tx_start}, 32'd0);
        check("reset_tx_data", {24'd0, tx_data}, 32'd0);
        check("reset_grant_id", {30'd0, grant_id}, 32'd0);

        // Single requester offering during holdoff; accepted as soon as IDLE.
        req_valid = 4'b0010;
        rst       = 1'b0;
        holdoff_check(4'b0010);
        do_grant(1, 8'hB1, 0);

        // Contention from ptr=1: 2,3,0,1,2.
        req_valid = 4'b1111;
        do_grant(2, 8'hC2, 112);
        do_grant(3, 8'hD3, 112);
        do_grant(0, 8'hA0, 112);
        do_grant(1, 8'hB1, 112);
        do_grant(2, 8'hC2, 112);

        // Fairness wrap from ptr=2 with valid=0011: 0 then 1.
        req_valid = 4'b0011;
        do_grant(0, 8'hA0, 112);
        do_grant(1, 8'hB1, 112);

        // Sole requester equal to ptr still wins.
        req_valid = 4'b0010;
        do_grant(1, 8'hB1, 112);

        // Reset at WAIT count 40 (currently at count 1).
        for (int i = 0; i < 39; i++) tick();
        rst       = 1'b1;
        req_valid = 4'b0110;
        tick();
        check("midreset_busy", {31'd0, busy}, 32'd1);
        check("midreset_tx_start", {31'd0, tx_start}, 32'd0);
        check("midreset_tx_data", {24'd0, tx_data}, 32'd0);
        check("midreset_grant_id", {30'd0, grant_id}, 32'd0);
        rst       = 1'b0;
        last_data = 8'h00;
        holdoff_check(4'b0010);
        do_grant(1, 8'hB1, 0);

`ifdef UART_ARB_PACKET_LOCK_EN
        // Requester 0 holds the grant through last=0,0,1, then requester 1.
        req_valid = 4'b0011;
        req_last  = 4'b1110;
        do_grant(0, 8'hA0, 112);
        do_grant(0, 8'hA0, 112);
        req_last  = 4'b1111;
        do_grant(0, 8'hA0, 112);
        do_grant(1, 8'hB1, 112);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
